// File: rtl/circ_mtx_vec_mul_seq.sv
// Sequential circulant matrix-vector multiplier: LANES MAC units sweep the columns
// for LANES rows per pass, with arithmetic mod 2^WORD_WIDTH-1 or mod 2^WORD_WIDTH.
module circ_mtx_vec_mul_seq #(
    parameter int WORD_WIDTH = 31,
    parameter int MTX_SIZE   = 16,
    parameter int LANES      = 4,
    parameter int MERSENNE   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] mtx_row [0:MTX_SIZE-1],
    input  logic [WORD_WIDTH-1:0] vec     [0:MTX_SIZE-1],
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] result  [0:MTX_SIZE-1]
);

    localparam int GROUPS = MTX_SIZE / LANES;
    localparam int KW     = $clog2(MTX_SIZE);
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int CW     = KW + 1;
    localparam logic [WORD_WIDTH-1:0] P = {WORD_WIDTH{1'b1}};

    generate
        if (LANES < 1 || (MTX_SIZE % LANES) != 0) begin : g_bad_lanes
            $error("circ_mtx_vec_mul_seq: LANES must divide MTX_SIZE");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t                r_state;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [KW-1:0]         r_k;
    logic [GW-1:0]         r_g;
    logic [WORD_WIDTH-1:0] r_mtx    [0:MTX_SIZE-1];
    logic [WORD_WIDTH-1:0] r_vec    [0:MTX_SIZE-1];
    logic [WORD_WIDTH-1:0] r_acc    [0:LANES-1];
    logic [WORD_WIDTH-1:0] r_result [0:MTX_SIZE-1];

    logic [CW-1:0]         w_row [0:LANES-1];
    logic [KW-1:0]         w_idx [0:LANES-1];
    logic [WORD_WIDTH-1:0] w_sum [0:LANES-1];

    // An input word equal to p is the same field element as 0.
    function automatic logic [WORD_WIDTH-1:0] canon(input logic [WORD_WIDTH-1:0] x);
        return (MERSENNE != 0 && x == P) ? {WORD_WIDTH{1'b0}} : x;
    endfunction

    function automatic logic [WORD_WIDTH-1:0] mul_red(input logic [WORD_WIDTH-1:0] a,
                                                      input logic [WORD_WIDTH-1:0] b);
        logic [2*WORD_WIDTH-1:0] full;
        logic [WORD_WIDTH:0]     f1;
        logic [WORD_WIDTH-1:0]   f2;
        full = {{WORD_WIDTH{1'b0}}, a} * {{WORD_WIDTH{1'b0}}, b};
        // 2^W == 1 mod p, so hi+lo folds the product; a second fold absorbs the carry.
        f1 = {1'b0, full[2*WORD_WIDTH-1:WORD_WIDTH]} + {1'b0, full[WORD_WIDTH-1:0]};
        f2 = f1[WORD_WIDTH-1:0] + {{(WORD_WIDTH-1){1'b0}}, f1[WORD_WIDTH]};
        if (MERSENNE == 0) return full[WORD_WIDTH-1:0];
        return (f2 == P) ? {WORD_WIDTH{1'b0}} : f2;
    endfunction

    function automatic logic [WORD_WIDTH-1:0] add_red(input logic [WORD_WIDTH-1:0] a,
                                                      input logic [WORD_WIDTH-1:0] b);
        logic [WORD_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (MERSENNE != 0 && s >= {1'b0, P}) s = s - {1'b0, P};
        return s[WORD_WIDTH-1:0];
    endfunction

    // Row r of lane l reads mtx_row[(k-r) mod N]; the +N form avoids negative values.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_row[l] = CW'(int'(r_g) * LANES + l);
            w_idx[l] = (CW'(r_k) < w_row[l]) ? KW'(CW'(r_k) + CW'(MTX_SIZE) - w_row[l])
                                             : KW'(CW'(r_k) - w_row[l]);
            w_sum[l] = add_red((r_k == '0) ? {WORD_WIDTH{1'b0}} : r_acc[l],
                               mul_red(r_mtx[w_idx[l]], r_vec[r_k]));
        end
    end

    // NOTE: operand registers are always loaded before they are read, so they carry no reset.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && r_in_ready && in_valid) begin
            for (int i = 0; i < MTX_SIZE; i++) begin
                r_mtx[i] <= canon(mtx_row[i]);
                r_vec[i] <= canon(vec[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_k         <= '0;
            r_g         <= '0;
            for (int l = 0; l < LANES; l++) r_acc[l] <= '0;
            for (int i = 0; i < MTX_SIZE; i++) r_result[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_in_ready && in_valid) begin
                        r_state    <= S_CALC;
                        r_in_ready <= 1'b0;
                        r_k        <= '0;
                        r_g        <= '0;
                    end
                end
                S_CALC: begin
                    for (int l = 0; l < LANES; l++) r_acc[l] <= w_sum[l];
                    if (r_k == KW'(MTX_SIZE - 1)) begin
                        for (int l = 0; l < LANES; l++) r_result[w_row[l][KW-1:0]] <= w_sum[l];
                        r_k <= '0;
                        if (r_g == GW'(GROUPS - 1)) begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_g <= r_g + GW'(1);
                        end
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;

endmodule

// File: tb/tb_circ_mtx_vec_mul_seq.sv
// Scoreboard bench for circ_mtx_vec_mul_seq: a Mersenne-31 16x16/4-lane instance and a
// truncating 8-bit 4x4/2-lane instance, checked against a direct modular model.
module tb_circ_mtx_vec_mul_seq;

    localparam int AW = 31, AN = 16, AL = 4;
    localparam int BW = 8,  BN = 4,  BL = 2;
    localparam longint unsigned P_A = 64'h7FFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [AW-1:0] a_mtx [0:AN-1];
    logic [AW-1:0] a_vec [0:AN-1];
    logic [AW-1:0] a_result [0:AN-1];
    logic b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [BW-1:0] b_mtx [0:BN-1];
    logic [BW-1:0] b_vec [0:BN-1];
    logic [BW-1:0] b_result [0:BN-1];

    int n_checks = 0;
    int n_fail   = 0;
    logic [AW*AN-1:0] exp_qa [$];
    logic [BW*BN-1:0] exp_qb [$];

    circ_mtx_vec_mul_seq #(.WORD_WIDTH(AW), .MTX_SIZE(AN), .LANES(AL), .MERSENNE(1)) u_dut_a (
        .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .mtx_row(a_mtx), .vec(a_vec), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .result(a_result));

    circ_mtx_vec_mul_seq #(.WORD_WIDTH(BW), .MTX_SIZE(BN), .LANES(BL), .MERSENNE(0)) u_dut_b (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .mtx_row(b_mtx), .vec(b_vec), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .result(b_result));

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW*AN-1:0] pack_a();
        logic [AW*AN-1:0] r;
        for (int i = 0; i < AN; i++) r[i*AW +: AW] = a_result[i];
        return r;
    endfunction

    function automatic logic [BW*BN-1:0] pack_b();
        logic [BW*BN-1:0] r;
        for (int i = 0; i < BN; i++) r[i*BW +: BW] = b_result[i];
        return r;
    endfunction

    // Element (i,j) of the circulant matrix is mtx_row[(j-i) mod N].
    function automatic logic [AW*AN-1:0] model_a();
        logic [AW*AN-1:0] r;
        longint unsigned acc, m, v;
        for (int i = 0; i < AN; i++) begin
            acc = 0;
            for (int j = 0; j < AN; j++) begin
                m   = 64'(a_mtx[(j - i + AN) % AN]) % P_A;
                v   = 64'(a_vec[j]) % P_A;
                acc = (acc + m * v) % P_A;
            end
            r[i*AW +: AW] = AW'(acc);
        end
        return r;
    endfunction

    function automatic logic [BW*BN-1:0] model_b();
        logic [BW*BN-1:0] r;
        longint unsigned acc;
        for (int i = 0; i < BN; i++) begin
            acc = 0;
            for (int j = 0; j < BN; j++)
                acc = (acc + 64'(b_mtx[(j - i + BN) % BN]) * 64'(b_vec[j])) % 256;
            r[i*BW +: BW] = BW'(acc);
        end
        return r;
    endfunction

    task automatic accept_a();
        int t = 0;
        exp_qa.push_back(model_a());
        @(negedge clk);
        a_in_valid = 1'b1;
        while (!a_in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("a_accept_timeout", 0, 1);
        @(posedge clk);
        #1 a_in_valid = 1'b0;
    endtask

    // Waits for the result, optionally stalls, then pops and compares at the handshake.
    task automatic finish_a(input string tag, input int hold, output logic [AW*AN-1:0] got);
        int lat = 0;
        logic [AW*AN-1:0] snap;
        got = '0;
        forever begin
            @(negedge clk);
            if (a_out_valid || lat > 500) break;
            @(posedge clk);
            lat++;
        end
        check({tag, "_latency"}, 512'(lat + 1), 512'(AN * AN / AL + 1));
        check({tag, "_in_ready_done"}, a_in_ready, 1'b0);
        snap = pack_a();
        for (int h = 0; h < hold; h++) begin
            a_in_valid = h[0];
            a_mtx[h] = AW'($urandom);
            @(posedge clk);
            @(negedge clk);
            check({tag, "_hold_valid"}, a_out_valid, 1'b1);
            check({tag, "_hold_in_ready"}, a_in_ready, 1'b0);
            check({tag, "_hold_stable"}, pack_a(), snap);
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        got = pack_a();
        if (exp_qa.size() == 0) check({tag, "_queue_empty"}, 0, 1);
        else check(tag, got, exp_qa.pop_front());
        @(posedge clk);
        #1 a_out_ready = 1'b0;
        check({tag, "_in_ready_after"}, a_in_ready, 1'b1);
        check({tag, "_out_valid_after"}, a_out_valid, 1'b0);
        if (hold > 0) begin
            repeat (3) @(negedge clk);
            check({tag, "_no_queued_job"}, {a_in_ready, a_out_valid}, 2'b10);
        end
    endtask

    task automatic run_b(input string tag);
        int t = 0;
        int lat = 0;
        exp_qb.push_back(model_b());
        @(negedge clk);
        b_in_valid = 1'b1;
        while (!b_in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("b_accept_timeout", 0, 1);
        @(posedge clk);
        #1 b_in_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (b_out_valid || lat > 100) break;
            @(posedge clk);
            lat++;
        end
        check({tag, "_latency"}, 512'(lat + 1), 512'(BN * BN / BL + 1));
        b_out_ready = 1'b1;
        if (exp_qb.size() == 0) check({tag, "_queue_empty"}, 0, 1);
        else check(tag, pack_b(), exp_qb.pop_front());
        @(posedge clk);
        #1 b_out_ready = 1'b0;
        check({tag, "_in_ready_after"}, b_in_ready, 1'b1);
    endtask

    logic [AW*AN-1:0] got;

    initial begin
        reset = 1'b1;
        {a_in_valid, a_out_ready, b_in_valid, b_out_ready} = '0;
        for (int i = 0; i < AN; i++) begin a_mtx[i] = '0; a_vec[i] = '0; end
        for (int i = 0; i < BN; i++) begin b_mtx[i] = '0; b_vec[i] = '0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_a_handshake", {a_in_ready, a_out_valid}, 2'b10);
        check("reset_a_result", pack_a(), '0);
        check("reset_b_handshake", {b_in_ready, b_out_valid}, 2'b10);
        reset = 1'b0;

        for (int i = 0; i < AN; i++) begin a_mtx[i] = (i == 0) ? 1 : 0; a_vec[i] = AW'(i); end
        accept_a();
        finish_a("identity", 0, got);

        for (int i = 0; i < AN; i++) begin a_mtx[i] = (i == 1) ? 1 : 0; a_vec[i] = AW'(100 + i); end
        accept_a();
        finish_a("wrap", 0, got);
        check("wrap_result15", got[15*AW +: AW], 100);

        for (int i = 0; i < AN; i++) begin a_mtx[i] = 31'h7FFF_FFFE; a_vec[i] = 31'h7FFF_FFFE; end
        accept_a();
        finish_a("mersenne_pm1", 0, got);
        check("mersenne_pm1_word0", got[0 +: AW], 16);

        for (int i = 0; i < AN; i++) begin a_mtx[i] = 31'h7FFF_FFFF; a_vec[i] = 31'h7FFF_FFFF; end
        accept_a();
        finish_a("mersenne_p", 0, got);

        for (int i = 0; i < AN; i++) begin a_mtx[i] = AW'($urandom); a_vec[i] = AW'($urandom); end
        accept_a();
        finish_a("backpressure", 10, got);

        // Abort partway through CALC, after the first group has been written.
        for (int i = 0; i < AN; i++) begin a_mtx[i] = (i == 1) ? 7 : 3; a_vec[i] = AW'(100 + i); end
        accept_a();
        repeat (19) @(posedge clk);
        @(negedge clk);
        check("abort_partial_seen", 512'(pack_a() != '0), 1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("abort_handshake", {a_in_ready, a_out_valid}, 2'b10);
        check("abort_result_clear", pack_a(), '0);
        void'(exp_qa.pop_back());

        for (int i = 0; i < AN; i++) begin a_mtx[i] = (i == 0) ? 1 : 0; a_vec[i] = AW'(i); end
        accept_a();
        finish_a("identity_after_abort", 0, got);

        for (int i = 0; i < AN; i++) begin a_mtx[i] = AW'($urandom); a_vec[i] = AW'($urandom); end
        a_mtx[3] = 31'h7FFF_FFFF;
        accept_a();
        finish_a("random", 0, got);

        for (int i = 0; i < BN; i++) begin b_mtx[i] = 8'hFF; b_vec[i] = 8'hFF; end
        run_b("trunc_all_ff");
        check("trunc_all_ff_word", 512'(b_result[2]), 4);
        for (int i = 0; i < BN; i++) begin b_mtx[i] = BW'($urandom); b_vec[i] = BW'($urandom); end
        run_b("trunc_random");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/circ_mtx_vec_mul_seq.md
Name: circ_mtx_vec_mul_seq

Overview:
Sequential, resource-shared circulant matrix-vector multiplier. The matrix is defined by its first row `mtx_row`. Row i is `mtx_row` circularly shifted right by i, so element (i,j) = mtx_row[(j-i) mod MTX_SIZE].
LANES multiply-accumulate units process LANES rows per pass, iterating over columns, which trades latency for area relative to the fully parallel dot-product array. Arithmetic is either modulo the Mersenne prime 2^WORD_WIDTH-1 (the Monolith field for WORD_WIDTH=31) or plain modulo 2^WORD_WIDTH. Input and output use valid/ready handshakes so the block sits between permutation-round stages.

Parameters:
WORD_WIDTH, 31, element width in bits (2..32)
MTX_SIZE, 16, matrix dimension / vector length (>=2)
LANES, 4, parallel MAC lanes; must divide MTX_SIZE, else elaboration error ($error)
MERSENNE, 1, 1 = arithmetic mod p = 2^WORD_WIDTH-1; 0 = arithmetic mod 2^WORD_WIDTH (truncation)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high
in_valid  input  1  mtx_row/vec valid
in_ready  output  1  block can accept an input
mtx_row  input  WORD_WIDTH x [0:MTX_SIZE-1]  first matrix row
vec  input  WORD_WIDTH x [0:MTX_SIZE-1]  input vector
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
result  output  WORD_WIDTH x [0:MTX_SIZE-1]  result[i] = sum_j M[i][j]*vec[j]

Behaviour:
- Reset: state IDLE, in_ready=1, out_valid=0, result all 0, accumulators, column counter and group counter all 0. A reset asserted mid-CALC or in DONE aborts the operation, discards any partial result and returns to IDLE next cycle. Reset has priority over all other inputs.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch mtx_row and vec into internal registers and go to CALC. Inputs are not sampled after the accept cycle.
  - CALC: in_ready=0, out_valid=0. Counters g in 0..MTX_SIZE/LANES-1 and k in 0..MTX_SIZE-1. Each cycle, lane l with row r=g*LANES+l does acc[l] <= (k==0 ? 0 : acc[l]) + mtx_row[(k-r) mod MTX_SIZE]*vec[k], reduced per MERSENNE. When k==MTX_SIZE-1, write the final sums to result[g*LANES+l] and clear k. If g is also last, go to DONE; otherwise increment g.
  - DONE: out_valid=1, in_ready=0, result held stable. On out_ready go to IDLE. in_ready rises the cycle after the output handshake; the block never accepts input in the same cycle as that handshake.
- Latency: the accept edge is cycle 0. CALC occupies cycles 1..MTX_SIZE*MTX_SIZE/LANES. out_valid is first high in cycle MTX_SIZE*MTX_SIZE/LANES+1. With defaults: 64 CALC cycles, out_valid in cycle 65.
- Wrap-around: the index (k-r) mod MTX_SIZE is computed without negative intermediates, as k-r+MTX_SIZE when k<r, else k-r.
- MERSENNE=1:
  - The 2*WORD_WIDTH product is folded as hi+lo, then folded again.
  - The value p is mapped to 0.
  - Accumulator addition is modular, producing a canonical value.
  - Input words equal to p are legal and treated as 0.
  - All result words are in [0, p-1].
- MERSENNE=0: product and sum are truncated to WORD_WIDTH bits.
- result is updated only for completed groups during CALC. During DONE it holds the full result. Downstream must sample result only when out_valid=1.
- in_valid while not in_ready is ignored; it has no effect and is not queued.

Test Plan:
- Identity: MTX_SIZE=16, LANES=4, mtx_row=[1,0,...,0], vec=[0..15] -> result=[0..15]. out_valid exactly 65 cycles after the accept edge.
- Wrap: mtx_row with a single 1 at index 1, vec=[100..115] -> result[i]=vec[(i+1) mod 16]. Check result[15]=100.
- Mersenne reduction: WORD_WIDTH=31, all mtx_row=all vec=p-1=0x7FFFFFFE -> every result=16. Then all inputs =0x7FFFFFFF (=p) -> every result=0.
- Truncation mode: WORD_WIDTH=8, MTX_SIZE=4, LANES=2, MERSENNE=0, all inputs 255 -> every result=4. out_valid at cycle 9.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, result stable, in_ready=0, and in_valid pulses are ignored. in_ready=1 the cycle after the out_ready handshake.
- Reset mid-op: assert reset at CALC cycle 20 -> next cycle state IDLE, out_valid=0, result all 0. A subsequent identity job completes correctly with full latency.
